ws2812_bit_enc: RTL and testbench
=================================

# ws2812_bit_enc

Serial line encoder directly downstream of the WS2812 frame controller. It accepts one data bit per `bit_rdy_in` pulse and drives the single-wire WS2812 output with the matching high/low waveform. It pulses `bit_done_out` when that bit's period ends, and a one-entry holding register allows back-to-back bits with no gap. Output `dout_out` drives the LED strip pin.

## Interface
- `T0H`, default 80: high time for a 0 bit, in clocks (0.40 µs @ 200 MHz).
- `T0L`, default 170: low time for a 0 bit, in clocks (0.85 µs).
- `T1H`, default 160: high time for a 1 bit, in clocks (0.80 µs).
- `T1L`, default 90: low time for a 1 bit, in clocks (0.45 µs).
- `CNT_W`, default 16: phase counter width. All timing parameters must be ≥ 2 and < 2^CNT_W.
- `clk_in`  in  1  system clock. Everything is on the rising edge.
- `rst_in`  in  1  asynchronous, active-high reset.
- `bit_rdy_in`  in  1  one-cycle strobe: `bit_data_in` is valid this cycle.
- `bit_data_in`  in  1  bit to encode. Sampled only when `bit_rdy_in` = 1.
- `overrun_clr_in`  in  1  clears `overrun_out`.
- `dout_out`  out  1  WS2812 serial line.
- `bit_done_out`  out  1  one-cycle pulse on the last low cycle of each bit.
- `busy_out`  out  1  high while a bit is being sent or the holding register is full.
- `overrun_out`  out  1  sticky flag: a strobe was dropped.

## Operation
- **States:**
  - IDLE: line low.
  - HIGH: line high for TxH cycles.
  - LOW: line low for TxL cycles.
- **Registers:** current bit `cur`, holding bit `hold`, `hold_vld`, phase counter `cnt` (CNT_W bits, counts down).
- **Load:** a bit is loaded into `cur` in these cases:
  - on `bit_rdy_in` in IDLE;
  - on `bit_rdy_in` in the last LOW cycle when `hold_vld` = 0;
  - from `hold` in the last LOW cycle when `hold_vld` = 1.
- **On load:**
  - next state is HIGH;
  - `cnt` = (cur ? T1H : T0H) − 1;
  - `hold_vld` clears if `hold` was consumed.
- **HIGH:**
  - `dout_out` = 1;
  - when `cnt` = 0: go to LOW, with `cnt` = (cur ? T1L : T0L) − 1;
  - otherwise decrement `cnt`.
- **LOW:**
  - `dout_out` = 0;
  - when `cnt` = 0 (the last LOW cycle): `bit_done_out` = 1. The next state is HIGH if a bit loads this cycle, otherwise IDLE.
- **Holding:** `bit_rdy_in` during HIGH or LOW, when not taken as a load:
  - if `hold_vld` = 0: store the bit in `hold` and set `hold_vld`;
  - if `hold_vld` = 1 and `hold` is not draining this cycle: drop the bit and set `overrun_out`.
- **Simultaneous events:**
  - `bit_rdy_in` in the last LOW cycle with `hold_vld` = 1: `hold` moves to `cur` and the new bit goes into `hold`. No overrun.
  - `overrun_clr_in` and a new overrun in the same cycle: set wins.
- **`busy_out`:** = (state ≠ IDLE) | `hold_vld`.

## Timing
- **Reset:** all outputs are 0 immediately, asynchronously:
  - `dout_out`, `bit_done_out`, `busy_out`, `overrun_out` = 0;
  - state = IDLE, `hold_vld` = 0, `cnt` = 0.
  - A reset mid-bit truncates the pulse at once. After release, the block waits for a new strobe.
- **All outputs are registered.**
- **Start latency:** strobe in cycle N (IDLE) → `dout_out` rises at the edge ending cycle N and is high in cycles N+1 … N+TxH.
- **Bit period:** exactly TxH high cycles, then TxL low cycles. `bit_done_out` is high in the final low cycle only.
- **Back-to-back:** the next bit's high phase starts the cycle immediately after `bit_done_out`. Period is exactly TxH + TxL with no idle cycle.
- **Strobe response:** upstream strobes on `bit_done_out` (or next cycle). The one-cycle response latency is absorbed by `hold`. Line continuity is guaranteed only if the strobe arrives no later than the last LOW cycle.

## Test plan
- **Single bit:**
  - reset, strobe `bit_data_in` = 1 at cycle 10 → `dout_out` high cycles 11–170, low 171–260;
  - `bit_done_out` only at 260; `busy_out` drops at 261.
- **Single zero:** strobe 0 at cycle 10 → high cycles 11–90, low 91–260, `bit_done_out` at 260.
- **Back-to-back:**
  - bits 1,0,1 with the second and third strobes in cycles where `hold_vld` = 0 (one during the first bit's HIGH) → contiguous waveform;
  - periods 250/250/250, high widths 160/80/160;
  - three `bit_done_out` pulses, no gaps.
- **Boundary load:** strobe exactly in a last-LOW cycle with `hold` empty → next HIGH starts the following cycle, no overrun.
- **Overrun:**
  - three strobes during one HIGH phase → third dropped, `overrun_out` = 1 and stays;
  - `overrun_clr_in` clears it, except when coincident with a new overrun (stays 1).
- **Reset mid-bit:** assert `rst_in` during HIGH → `dout_out` = 0 the same cycle, asynchronously, `busy_out` = 0. After release, a strobe produces a correct full bit.

Source files
------------

// File: rtl/ws2812_bit_enc.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : ws2812_bit_enc                                              |
// | Brief    : WS2812 single-wire bit encoder. One strobed bit becomes one |
// |            high/low pulse pair; a one-deep holding register lets       |
// |            upstream answer bit_done_out without a gap on the line.     |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module ws2812_bit_enc #(
  parameter int T0H   = 80,
  parameter int T0L   = 170,
  parameter int T1H   = 160,
  parameter int T1L   = 90,
  parameter int CNT_W = 16
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic bit_rdy_in,
  input  logic bit_data_in,
  input  logic overrun_clr_in,
  output logic dout_out,
  output logic bit_done_out,
  output logic busy_out,
  output logic overrun_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  // Phase lengths minus one: the counter runs from N-1 down to 0.
  localparam logic [CNT_W-1:0] c_T0H_M1 = CNT_W'(T0H - 1);
  localparam logic [CNT_W-1:0] c_T0L_M1 = CNT_W'(T0L - 1);
  localparam logic [CNT_W-1:0] c_T1H_M1 = CNT_W'(T1H - 1);
  localparam logic [CNT_W-1:0] c_T1L_M1 = CNT_W'(T1L - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cur;
  logic             r_hold;
  logic             r_hold_vld;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_cur_nxt;
  logic             w_hold_vld_nxt;
  logic             w_last;
  logic             w_load;
  logic             w_load_bit;
  logic             w_drain;
  logic             w_hold_store;
  logic             w_ovr;

  // Next-state decode; outputs are registered from these next values so
  // every output changes exactly on the edge that enters its phase.
  always_comb begin
    w_last       = (r_state == S_LOW) && (r_cnt == '0);
    w_drain      = w_last && r_hold_vld;
    w_load       = ((r_state == S_IDLE) && bit_rdy_in) ||
                   (w_last && (r_hold_vld || bit_rdy_in));
    w_load_bit   = w_drain ? r_hold : bit_data_in;
    // While draining, the slot frees up this cycle, so a new strobe still fits.
    w_hold_store = bit_rdy_in && (r_state != S_IDLE) &&
                   (w_last ? r_hold_vld : !r_hold_vld);
    w_ovr        = bit_rdy_in && (r_state != S_IDLE) && !w_last && r_hold_vld;

    w_hold_vld_nxt = r_hold_vld;
    if (w_hold_store)
      w_hold_vld_nxt = 1'b1;
    else if (w_drain)
      w_hold_vld_nxt = 1'b0;

    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cur_nxt   = r_cur;
    if (w_load) begin
      w_state_nxt = S_HIGH;
      w_cur_nxt   = w_load_bit;
      w_cnt_nxt   = w_load_bit ? c_T1H_M1 : c_T0H_M1;
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_IDLE;
        S_HIGH: begin
          if (r_cnt == '0) begin
            w_state_nxt = S_LOW;
            w_cnt_nxt   = r_cur ? c_T1L_M1 : c_T0L_M1;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
        S_LOW: begin
          if (r_cnt == '0)
            w_state_nxt = S_IDLE;
          else
            w_cnt_nxt = r_cnt - 1'b1;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State, datapath and registered outputs; reset drops the line at once.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_cur        <= 1'b0;
      r_hold       <= 1'b0;
      r_hold_vld   <= 1'b0;
      dout_out     <= 1'b0;
      bit_done_out <= 1'b0;
      busy_out     <= 1'b0;
      overrun_out  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_cur      <= w_cur_nxt;
      r_hold_vld <= w_hold_vld_nxt;
      if (w_hold_store)
        r_hold <= bit_data_in;
      dout_out     <= (w_state_nxt == S_HIGH);
      bit_done_out <= (w_state_nxt == S_LOW) && (w_cnt_nxt == '0);
      busy_out     <= (w_state_nxt != S_IDLE) || w_hold_vld_nxt;
      // A fresh overrun outranks a coincident clear.
      if (w_ovr)
        overrun_out <= 1'b1;
      else if (overrun_clr_in)
        overrun_out <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ws2812_bit_enc.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_ws2812_bit_enc                                           |
// | Brief    : Self-checking bench for ws2812_bit_enc. Accepted bits push  |
// |            their expected high/low widths; a line monitor pops them on |
// |            every bit_done_out and compares measured widths.            |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_ws2812_bit_enc;

  localparam int T0H = 80;
  localparam int T0L = 170;
  localparam int T1H = 160;
  localparam int T1L = 90;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b0;
  logic din = 1'b0;
  logic clr = 1'b0;
  logic dout, done, busy, ovr;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int h;
    int l;
  } exp_t;
  exp_t sb[$];

  ws2812_bit_enc #(
    .T0H(T0H), .T0L(T0L), .T1H(T1H), .T1L(T1L), .CNT_W(16)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .bit_rdy_in    (rdy),
    .bit_data_in   (din),
    .overrun_clr_in(clr),
    .dout_out      (dout),
    .bit_done_out  (done),
    .busy_out      (busy),
    .overrun_out   (ovr)
  );

  always #5 clk = ~clk;

  // Line monitor: measures each pulse pair and checks it against the scoreboard.
  int  mon_hi = 0;
  int  mon_lo = 0;
  logic mon_pd = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      mon_hi = 0;
      mon_lo = 0;
      mon_pd = 1'b0;
    end else begin
      if (dout) begin
        if (!mon_pd) begin
          mon_hi = 1;
          mon_lo = 0;
        end else begin
          mon_hi++;
        end
      end else if (mon_hi != 0) begin
        mon_lo++;
      end
      mon_pd = dout;
      if (done) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected_done: got high=%0d low=%0d, expected no bit", mon_hi, mon_lo);
        end else begin
          e = sb.pop_front();
          if (mon_hi !== e.h || mon_lo !== e.l) begin
            n_err++;
            $display("FAIL sb_bit_widths: got high=%0d low=%0d, expected high=%0d low=%0d",
                     mon_hi, mon_lo, e.h, e.l);
          end
        end
        mon_hi = 0;
        mon_lo = 0;
      end
    end
  end

  task automatic push_exp(input logic b);
    exp_t e;
    e.h = b ? T1H : T0H;
    e.l = b ? T1L : T0L;
    sb.push_back(e);
  endtask

  // One cycle: drive inputs just after the edge, return at the falling edge.
  task automatic step(input logic r, input logic d, input logic c);
    @(posedge clk);
    #1;
    rdy = r;
    din = d;
    clr = c;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    rdy = 1'b0;
    clr = 1'b0;
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk(input string name, input logic got, input logic exp_v);
    n_cmp++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, got, exp_v);
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("reset_dout", dout, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_overrun", ovr, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Strobe at cycle 10 after reset, then check every cycle of the bit.
  task automatic test_single(input logic b);
    int th, tl;
    th = b ? T1H : T0H;
    tl = b ? T1L : T0L;
    do_reset();
    repeat (9) step(1'b0, 1'b0, 1'b0);
    step(1'b1, b, 1'b0);
    push_exp(b);
    for (int k = 1; k <= th + tl + 2; k++) begin
      step(1'b0, 1'b0, 1'b0);
      chk($sformatf("single%0b_dout_k%0d", b, k), dout, (k >= 1 && k <= th));
      chk($sformatf("single%0b_done_k%0d", b, k), done, (k == th + tl));
      chk($sformatf("single%0b_busy_k%0d", b, k), busy, (k >= 1 && k <= th + tl));
    end
  endtask

  task automatic test_back_to_back();
    int dc[$];
    logic r, d;
    do_reset();
    for (int j = 0; j <= 760; j++) begin
      r = (j == 0 || j == 20 || j == 260);
      d = (j != 20);
      step(r, d, 1'b0);
      if (r) push_exp(d);
      if (done) dc.push_back(j);
      if (j == 251) chk("b2b_dout_after_done1", dout, 1'b1);
      if (j == 501) chk("b2b_dout_after_done2", dout, 1'b1);
    end
    n_cmp++;
    if (dc.size() != 3) begin
      n_err++;
      $display("FAIL b2b_done_count: got %0d, expected 3", dc.size());
    end else begin
      n_cmp += 3;
      if (dc[0] != 250) begin
        n_err++;
        $display("FAIL b2b_done0_cycle: got %0d, expected 250", dc[0]);
      end
      if (dc[1] - dc[0] != 250) begin
        n_err++;
        $display("FAIL b2b_period1: got %0d, expected 250", dc[1] - dc[0]);
      end
      if (dc[2] - dc[1] != 250) begin
        n_err++;
        $display("FAIL b2b_period2: got %0d, expected 250", dc[2] - dc[1]);
      end
    end
  endtask

  task automatic test_boundary();
    logic r, d;
    do_reset();
    for (int j = 0; j <= 510; j++) begin
      r = (j == 0 || j == 250);
      d = (j == 0);
      step(r, d, 1'b0);
      if (r) push_exp(d);
      if (j == 250) chk("bnd_done_at_strobe", done, 1'b1);
      if (j == 251) chk("bnd_dout_next_high", dout, 1'b1);
      if (j == 500) chk("bnd_done_second", done, 1'b1);
    end
    chk("bnd_no_overrun", ovr, 1'b0);
  endtask

  task automatic test_overrun();
    logic r, d, c;
    do_reset();
    for (int j = 0; j <= 520; j++) begin
      r = (j == 0 || j == 5 || j == 6 || j == 120);
      d = (j == 0);
      c = (j == 100 || j == 120 || j == 130);
      step(r, d, c);
      if (j == 0 || j == 5) push_exp(d);
      if (j == 6)   chk("ovr_before_drop", ovr, 1'b0);
      if (j == 7)   chk("ovr_set", ovr, 1'b1);
      if (j == 100) chk("ovr_sticky", ovr, 1'b1);
      if (j == 101) chk("ovr_cleared", ovr, 1'b0);
      if (j == 121) chk("ovr_set_beats_clear", ovr, 1'b1);
      if (j == 131) chk("ovr_cleared_again", ovr, 1'b0);
      if (j == 300) chk("ovr_busy_second_bit", busy, 1'b1);
      if (j == 501) chk("ovr_busy_dropped", busy, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    logic r;
    do_reset();
    for (int j = 0; j <= 50; j++) begin
      step(j == 0, 1'b1, 1'b0);
      if (j == 0) push_exp(1'b1);
    end
    chk("mid_dout_high_before", dout, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_dout_async_low", dout, 1'b0);
    chk("mid_busy_async_low", busy, 1'b0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int j = 0; j <= 255; j++) begin
      r = (j == 0);
      step(r, 1'b0, 1'b0);
      if (r) push_exp(1'b0);
      if (j == 1)   chk("mid_after_dout_rise", dout, 1'b1);
      if (j == 80)  chk("mid_after_dout_last_high", dout, 1'b1);
      if (j == 81)  chk("mid_after_dout_low", dout, 1'b0);
      if (j == 250) chk("mid_after_done", done, 1'b1);
      if (j == 251) chk("mid_after_idle", busy, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_single(1'b1);
    test_single(1'b0);
    test_back_to_back();
    test_boundary();
    test_overrun();
    test_reset_mid();
    repeat (2) step(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: got %0d pending bits, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
